// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - instruction-side control bundle between the LEGv8 controller and datapath
// The illegal flag exists only when ILLEGAL_TRAP_EN is defined.
interface multicycle_control_if #(
  parameter int INSTR_W = 32,
  parameter int ALUOP_W = 3
);
  logic [INSTR_W-1:0] instruction;
  logic               alu_zero;
  logic               alu_n;
  logic               alu_z;
  logic               alu_c;
  logic               alu_v;

  logic               pc_en;
  logic               uncond_br;
  logic               br_taken;
  logic               reg2loc;
  logic               reg_write;
  logic               alu_src;
  logic [ALUOP_W-1:0] alu_op;
  logic               mem_write;
  logic               mem_to_reg;
  logic [INSTR_W-1:0] ir;
  logic [3:0]         flags;
  logic [2:0]         state;
`ifdef ILLEGAL_TRAP_EN
  logic               illegal;

  modport master (
    input  instruction, alu_zero, alu_n, alu_z, alu_c, alu_v,
    output pc_en, uncond_br, br_taken, reg2loc, reg_write, alu_src, alu_op,
           mem_write, mem_to_reg, ir, flags, state, illegal
  );

  modport slave (
    output instruction, alu_zero, alu_n, alu_z, alu_c, alu_v,
    input  pc_en, uncond_br, br_taken, reg2loc, reg_write, alu_src, alu_op,
           mem_write, mem_to_reg, ir, flags, state, illegal
  );
`else
  modport master (
    input  instruction, alu_zero, alu_n, alu_z, alu_c, alu_v,
    output pc_en, uncond_br, br_taken, reg2loc, reg_write, alu_src, alu_op,
           mem_write, mem_to_reg, ir, flags, state
  );

  modport slave (
    output instruction, alu_zero, alu_n, alu_z, alu_c, alu_v,
    input  pc_en, uncond_br, br_taken, reg2loc, reg_write, alu_src, alu_op,
           mem_write, mem_to_reg, ir, flags, state
  );
`endif
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - LEGv8 multicycle control FSM (FETCH/DECODE/EXEC/MEM/WB) with NZCV register
// Define ILLEGAL_TRAP_EN to trap unrecognised opcodes in a sticky HALT state.
module multicycle_control #(
  parameter int INSTR_W = 32,
  parameter int ALUOP_W = 3
) (
  input  logic                clk,
  input  logic                reset,
  multicycle_control_if.master bus
);

  localparam logic [2:0] S_FETCH  = 3'b000;
  localparam logic [2:0] S_DECODE = 3'b001;
  localparam logic [2:0] S_EXEC   = 3'b010;
  localparam logic [2:0] S_MEM    = 3'b011;
  localparam logic [2:0] S_WB     = 3'b100;
`ifdef ILLEGAL_TRAP_EN
  localparam logic [2:0] S_HALT   = 3'b111;
`endif

  localparam logic [3:0] C_NOP  = 4'd0;
  localparam logic [3:0] C_ADDI = 4'd1;
  localparam logic [3:0] C_ADDS = 4'd2;
  localparam logic [3:0] C_SUBS = 4'd3;
  localparam logic [3:0] C_LDUR = 4'd4;
  localparam logic [3:0] C_STUR = 4'd5;
  localparam logic [3:0] C_B    = 4'd6;
  localparam logic [3:0] C_BLT  = 4'd7;
  localparam logic [3:0] C_CBZ  = 4'd8;

  localparam logic [ALUOP_W-1:0] OP_PASS = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] OP_ADD  = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] OP_SUB  = ALUOP_W'(3);

  logic [2:0]         state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [3:0]         flags_q, flags_d;

  logic [3:0]         iclass;
  logic               active;
  logic               retire;
  logic               flag_we;
  logic               br_cond;

  logic               dec_reg2loc;
  logic               dec_alu_src;
  logic [ALUOP_W-1:0] dec_alu_op;
  logic               dec_uncond_br;
  logic               dec_mem_to_reg;

  always_comb begin
    iclass = C_NOP;
    if (ir_q[31:22] == 10'b1001000100)
      iclass = C_ADDI;
    else if (ir_q[31:21] == 11'b10101011000)
      iclass = C_ADDS;
    else if (ir_q[31:21] == 11'b11101011000)
      iclass = C_SUBS;
    else if (ir_q[31:21] == 11'b11111000010)
      iclass = C_LDUR;
    else if (ir_q[31:21] == 11'b11111000000)
      iclass = C_STUR;
    else if (ir_q[31:26] == 6'b000101)
      iclass = C_B;
    else if (ir_q[31:24] == 8'b01010100 && ir_q[4:0] == 5'b01011)
      iclass = C_BLT;
    else if (ir_q[31:24] == 8'b10110100)
      iclass = C_CBZ;
  end

  always_comb begin
    dec_reg2loc    = 1'b0;
    dec_alu_src    = 1'b0;
    dec_alu_op     = OP_PASS;
    dec_uncond_br  = 1'b0;
    dec_mem_to_reg = 1'b0;
    case (iclass)
      C_ADDI: begin
        dec_alu_src = 1'b1;
        dec_alu_op  = OP_ADD;
      end
      C_ADDS: begin
        dec_reg2loc = 1'b1;
        dec_alu_op  = OP_ADD;
      end
      C_SUBS: begin
        dec_reg2loc = 1'b1;
        dec_alu_op  = OP_SUB;
      end
      C_LDUR: begin
        dec_alu_src    = 1'b1;
        dec_alu_op     = OP_ADD;
        dec_mem_to_reg = 1'b1;
      end
      C_STUR: begin
        dec_alu_src = 1'b1;
        dec_alu_op  = OP_ADD;
      end
      C_B:     dec_uncond_br = 1'b1;
      default: ;
    endcase
  end

  // Static controls are held from DECODE to retirement; FETCH (and HALT) drive zeros.
  assign active = (state_q == S_DECODE) || (state_q == S_EXEC) ||
                  (state_q == S_MEM)    || (state_q == S_WB);

  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_WB:   retire = 1'b1;
      S_MEM:  retire = (iclass == C_STUR);
      S_EXEC: retire = (iclass == C_B) || (iclass == C_BLT) ||
                       (iclass == C_CBZ) || (iclass == C_NOP);
      default: retire = 1'b0;
    endcase
  end

  // B.LT reads the registered flags, so a preceding ADDS/SUBS is already visible.
  always_comb begin
    br_cond = 1'b0;
    case (iclass)
      C_B:     br_cond = 1'b1;
      C_BLT:   br_cond = flags_q[3] ^ flags_q[0];
      C_CBZ:   br_cond = bus.alu_zero;
      default: br_cond = 1'b0;
    endcase
  end

  assign flag_we = (state_q == S_EXEC) && ((iclass == C_ADDS) || (iclass == C_SUBS));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
`ifdef ILLEGAL_TRAP_EN
        if (iclass == C_NOP)
          state_d = S_HALT;
        else
          state_d = S_EXEC;
`else
        state_d = S_EXEC;
`endif
      end
      S_EXEC: begin
        case (iclass)
          C_ADDI, C_ADDS, C_SUBS: state_d = S_WB;
          C_LDUR, C_STUR:         state_d = S_MEM;
          default:                state_d = S_FETCH;
        endcase
      end
      S_MEM:    state_d = (iclass == C_STUR) ? S_FETCH : S_WB;
      S_WB:     state_d = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
      S_HALT:   state_d = S_HALT;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ir_d = ir_q;
    if (state_q == S_FETCH)
      ir_d = bus.instruction;
  end

  always_comb begin
    flags_d = flags_q;
    if (flag_we)
      flags_d = {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
    end
  end

  assign bus.pc_en      = retire;
  assign bus.br_taken   = retire && (state_q == S_EXEC) && br_cond;
  assign bus.reg_write  = (state_q == S_WB);
  assign bus.mem_write  = (state_q == S_MEM) && (iclass == C_STUR);
  assign bus.reg2loc    = active && dec_reg2loc;
  assign bus.alu_src    = active && dec_alu_src;
  assign bus.alu_op     = active ? dec_alu_op : OP_PASS;
  assign bus.uncond_br  = active && dec_uncond_br;
  assign bus.mem_to_reg = active && dec_mem_to_reg;
  assign bus.ir         = ir_q;
  assign bus.flags      = flags_q;
  assign bus.state      = state_q;
`ifdef ILLEGAL_TRAP_EN
  assign bus.illegal    = (state_q == S_HALT);
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed table-driven bench for multicycle_control
module tb_multicycle_control;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_control_if bus_if ();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        zero;
    logic [3:0]  nzcv;
    int          cycles;
    logic [14:0] states;
    logic [6:0]  ctl;
    int          n_rw;
    int          n_mw;
    logic        br;
    logic [3:0]  flags;
  } vec_t;

  localparam logic [14:0] SEQ3  = 15'b000_000_000_001_010;
  localparam logic [14:0] SEQ4W = 15'b000_000_001_010_100;
  localparam logic [14:0] SEQ4M = 15'b000_000_001_010_011;
  localparam logic [14:0] SEQ5  = 15'b000_001_010_011_100;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [6:0] ctl_now();
    return {bus_if.alu_src, bus_if.alu_op, bus_if.reg2loc, bus_if.uncond_br, bus_if.mem_to_reg};
  endfunction

  function automatic logic [3:0] strobes_now();
    return {bus_if.pc_en, bus_if.reg_write, bus_if.mem_write, bus_if.br_taken};
  endfunction

  task automatic run_vec(input vec_t v);
    logic [14:0] seq;
    logic [6:0]  ctl_dec, ctl_ret;
    logic [31:0] ir_ret;
    logic        br, done, fetch_zero;
    int          cyc, rw, mw, stray;
    seq = '0; ctl_dec = '0; ctl_ret = '0; ir_ret = '0;
    br = 1'b0; done = 1'b0;
    cyc = 0; rw = 0; mw = 0; stray = 0;
    bus_if.instruction = v.instr;
    bus_if.alu_zero    = v.zero;
    {bus_if.alu_n, bus_if.alu_z, bus_if.alu_c, bus_if.alu_v} = v.nzcv;
    fetch_zero = (ctl_now() == 7'd0) && (strobes_now() == 4'd0);
    while (!done && cyc < 10) begin
      seq = {seq[11:0], bus_if.state};
      if (bus_if.state == 3'b001) ctl_dec = ctl_now();
      if (bus_if.reg_write) rw++;
      if (bus_if.mem_write) mw++;
      if (bus_if.br_taken && !bus_if.pc_en) stray++;
      if (bus_if.pc_en) begin
        done    = 1'b1;
        br      = bus_if.br_taken;
        ctl_ret = ctl_now();
        ir_ret  = bus_if.ir;
      end
      @(posedge clk);
      @(negedge clk);
      // anything on instruction past FETCH must be ignored
      bus_if.instruction = ~v.instr;
      cyc++;
    end
    check({v.name, " cycles"},     32'(cyc),        32'(v.cycles));
    check({v.name, " states"},     32'(seq),        32'(v.states));
    check({v.name, " fetch_ctl"},  32'(fetch_zero), 32'd1);
    check({v.name, " ctl_decode"}, 32'(ctl_dec),    32'(v.ctl));
    check({v.name, " ctl_retire"}, 32'(ctl_ret),    32'(v.ctl));
    check({v.name, " ir"},         ir_ret,          v.instr);
    check({v.name, " reg_write"},  32'(rw),         32'(v.n_rw));
    check({v.name, " mem_write"},  32'(mw),         32'(v.n_mw));
    check({v.name, " br_taken"},   32'(br),         32'(v.br));
    check({v.name, " stray_br"},   32'(stray),      32'd0);
    check({v.name, " flags"},      32'(bus_if.flags), 32'(v.flags));
    check({v.name, " next_fetch"}, 32'(bus_if.state), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[14];
    vec_t nop_v;
    int   k;
    logic [3:0] bad;

    vecs[0]  = '{"addi",   32'h91000421, 1'b0, 4'b1111, 4, SEQ4W, 7'b1_010_0_0_0, 1, 0, 1'b0, 4'b0000};
    vecs[1]  = '{"subs_n", 32'hEB020020, 1'b0, 4'b1000, 4, SEQ4W, 7'b0_011_1_0_0, 1, 0, 1'b0, 4'b1000};
    vecs[2]  = '{"blt_t1", 32'h5400004B, 1'b0, 4'b0101, 3, SEQ3,  7'b0_000_0_0_0, 0, 0, 1'b1, 4'b1000};
    vecs[3]  = '{"subs_z", 32'hEB020020, 1'b1, 4'b0110, 4, SEQ4W, 7'b0_011_1_0_0, 1, 0, 1'b0, 4'b0110};
    vecs[4]  = '{"blt_n1", 32'h5400004B, 1'b0, 4'b1000, 3, SEQ3,  7'b0_000_0_0_0, 0, 0, 1'b0, 4'b0110};
    vecs[5]  = '{"adds_nv",32'hAB020020, 1'b0, 4'b1001, 4, SEQ4W, 7'b0_010_1_0_0, 1, 0, 1'b0, 4'b1001};
    vecs[6]  = '{"blt_n2", 32'h5400004B, 1'b0, 4'b0000, 3, SEQ3,  7'b0_000_0_0_0, 0, 0, 1'b0, 4'b1001};
    vecs[7]  = '{"adds_v", 32'hAB020020, 1'b0, 4'b0001, 4, SEQ4W, 7'b0_010_1_0_0, 1, 0, 1'b0, 4'b0001};
    vecs[8]  = '{"blt_t2", 32'h5400004B, 1'b0, 4'b1110, 3, SEQ3,  7'b0_000_0_0_0, 0, 0, 1'b1, 4'b0001};
    vecs[9]  = '{"ldur",   32'hF8400020, 1'b0, 4'b1111, 5, SEQ5,  7'b1_010_0_0_1, 1, 0, 1'b0, 4'b0001};
    vecs[10] = '{"stur",   32'hF8000020, 1'b0, 4'b1111, 4, SEQ4M, 7'b1_010_0_0_0, 0, 1, 1'b0, 4'b0001};
    vecs[11] = '{"cbz_t",  32'hB4000041, 1'b1, 4'b1111, 3, SEQ3,  7'b0_000_0_0_0, 0, 0, 1'b1, 4'b0001};
    vecs[12] = '{"cbz_n",  32'hB4000041, 1'b0, 4'b1111, 3, SEQ3,  7'b0_000_0_0_0, 0, 0, 1'b0, 4'b0001};
    vecs[13] = '{"b",      32'h14000003, 1'b0, 4'b1111, 3, SEQ3,  7'b0_001_0_1_0, 0, 0, 1'b1, 4'b0001};
    vecs[13].ctl = 7'b0_000_0_1_0;
    nop_v    = '{"nop",    32'h00000000, 1'b0, 4'b1111, 3, SEQ3,  7'b0_000_0_0_0, 0, 0, 1'b0, 4'b0000};

    reset = 1'b0;
    bus_if.instruction = 32'h91000421;
    bus_if.alu_zero = 1'b0;
    {bus_if.alu_n, bus_if.alu_z, bus_if.alu_c, bus_if.alu_v} = 4'b0000;
    repeat (3) @(negedge clk);
    check("rst state",   32'(bus_if.state), 32'd0);
    check("rst ir",      bus_if.ir,         32'd0);
    check("rst flags",   32'(bus_if.flags), 32'd0);
    check("rst strobes", 32'(strobes_now()), 32'd0);
    check("rst ctl",     32'(ctl_now()),    32'd0);

    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rel ir",    bus_if.ir,         32'h91000421);
    check("rel state", 32'(bus_if.state), 32'd1);
    k = 0;
    while (bus_if.state != 3'b000 && k < 8) begin
      @(negedge clk);
      k++;
    end
    check("rel drain", 32'(bus_if.state), 32'd0);

    for (int i = 0; i < 14; i++) run_vec(vecs[i]);

    // reset falling in the MEM cycle of STUR must kill mem_write at once
    bus_if.instruction = 32'hF8000020;
    k = 0;
    while (bus_if.state != 3'b011 && k < 6) begin
      @(negedge clk);
      k++;
    end
    check("abort in_mem",  32'(bus_if.mem_write), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("abort mem_write", 32'(bus_if.mem_write), 32'd0);
    check("abort state",     32'(bus_if.state),     32'd0);
    check("abort flags",     32'(bus_if.flags),     32'd0);
    @(negedge clk);
    check("abort strobes",   32'(strobes_now()),    32'd0);
    bus_if.instruction = 32'h00000000;
    reset = 1'b1;

`ifdef ILLEGAL_TRAP_EN
    @(posedge clk);
    @(negedge clk);
    check("trap decode", 32'(bus_if.state), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("trap state",   32'(bus_if.state),   32'd7);
    check("trap illegal", 32'(bus_if.illegal), 32'd1);
    bad = 4'd0;
    for (int c = 0; c < 10; c++) begin
      bad = bad | strobes_now();
      @(negedge clk);
    end
    check("trap strobes", 32'(bad),            32'd0);
    check("trap held",    32'(bus_if.state),   32'd7);
    check("trap ctl",     32'(ctl_now()),      32'd0);
    reset = 1'b0;
    #1;
    check("trap exit state",   32'(bus_if.state),   32'd0);
    check("trap exit illegal", 32'(bus_if.illegal), 32'd0);
    @(negedge clk);
    reset = 1'b1;
`else
    run_vec(nop_v);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
